// File: rtl/imem_fetch_if.sv
// Bus bundle between the fetch controller and its surroundings: loader port,
// instruction memory port, branch redirect and the fetch output stage.
interface imem_fetch_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              start;
    logic              halt_req;
    logic              ld_req;
    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic [ADDR_W:0]   ld_count;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              br_valid;
    logic [15:0]       br_target;
    logic              if_valid;
    logic              if_ready;
    logic [DATA_W-1:0] if_instr;
    logic [15:0]       if_pc;
    logic              halted;

    modport master (
        input  start, halt_req, ld_req, ld_valid, ld_addr, ld_data,
        input  mem_rdata, br_valid, br_target, if_ready,
        output ld_ready, ld_count, mem_addr, mem_we, mem_wdata,
        output if_valid, if_instr, if_pc, halted
    );

    modport slave (
        output start, halt_req, ld_req, ld_valid, ld_addr, ld_data,
        output mem_rdata, br_valid, br_target, if_ready,
        input  ld_ready, ld_count, mem_addr, mem_we, mem_wdata,
        input  if_valid, if_instr, if_pc, halted
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction memory sequencer: program loading in LOAD, one-per-cycle fetch
// into a registered valid/ready stage in RUN, with redirect and halt.
module imem_fetch_ctrl #(
    parameter int          ADDR_W   = 8,
    parameter int          DATA_W   = 16,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_fetch_if.master  bus
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HALT} state_t;

    localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic [15:0]       pc_q, pc_d;
    logic              if_valid_q, if_valid_d;
    logic [DATA_W-1:0] if_instr_q, if_instr_d;
    logic [15:0]       if_pc_q, if_pc_d;
    logic [ADDR_W:0]   ld_count_q, ld_count_d;

    function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
            ld_count_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            ld_count_q <= ld_count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        ld_count_d = ld_count_q;
        unique case (state_q)
            S_IDLE, S_HALT: begin
                if_valid_d = 1'b0;
                if (bus.ld_req) begin
                    state_d    = S_LOAD;
                    ld_count_d = '0;
                end else if (bus.start) begin
                    state_d = S_RUN;
                end
            end
            S_LOAD: begin
                if (bus.ld_valid) ld_count_d = sat_inc(ld_count_q);
                if (!bus.ld_req) begin
                    state_d = S_IDLE;
                    pc_d    = RESET_PC;
                end
            end
            S_RUN: begin
                // Redirect and halt both kill the slot; a pending handshake
                // this cycle has already been consumed by decode.
                if (bus.halt_req) begin
                    state_d    = S_HALT;
                    if_valid_d = 1'b0;
                    if (bus.br_valid) pc_d = bus.br_target;
                end else if (bus.br_valid) begin
                    pc_d       = bus.br_target;
                    if_valid_d = 1'b0;
                end else if (!if_valid_q || bus.if_ready) begin
                    if_instr_d = bus.mem_rdata;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    pc_d       = pc_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.ld_ready  = (state_q == S_LOAD);
    assign bus.mem_we    = (state_q == S_LOAD) && bus.ld_valid;
    assign bus.mem_addr  = (state_q == S_LOAD) ? bus.ld_addr : pc_q[ADDR_W-1:0];
    assign bus.mem_wdata = (state_q == S_LOAD) ? bus.ld_data : '0;
    assign bus.ld_count  = ld_count_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_instr  = if_instr_q;
    assign bus.if_pc     = if_pc_q;
    assign bus.halted    = (state_q == S_HALT);
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a small behavioural 256x16 memory.
module tb_imem_fetch_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    imem_fetch_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    imem_fetch_ctrl #(.ADDR_W(8), .DATA_W(16), .RESET_PC(16'h0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Unwritten locations read a fixed pattern: 0x80 holds 5555, others 10xx.
    logic [15:0] wmem [256];
    logic        written [256];

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) written[i] <= 1'b0;
        end else if (bus.mem_we) begin
            wmem[bus.mem_addr]    <= bus.mem_wdata;
            written[bus.mem_addr] <= 1'b1;
        end
    end

    function automatic logic [15:0] rd(input logic [7:0] a);
        if (written[a]) return wmem[a];
        if (a == 8'h80) return 16'h5555;
        return {8'h10, a};
    endfunction

    assign bus.mem_rdata = rd(bus.mem_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [15:0] pc, input logic [15:0] ins);
        chk({tag, ".v"}, {31'd0, bus.if_valid}, 32'd1);
        chk({tag, ".pc"}, {16'd0, bus.if_pc}, {16'd0, pc});
        chk({tag, ".ins"}, {16'd0, bus.if_instr}, {16'd0, ins});
    endtask

    initial begin
        bus.start = 0; bus.halt_req = 0; bus.ld_req = 0; bus.ld_valid = 0;
        bus.ld_addr = 0; bus.ld_data = 0; bus.br_valid = 0; bus.br_target = 0;
        bus.if_ready = 1;
        tick(); tick();
        clr = 0;
        rst_n = 1;
        tick();
        chk("rst.valid", {31'd0, bus.if_valid}, 32'd0);
        chk("rst.halted", {31'd0, bus.halted}, 32'd0);
        chk("rst.ldrdy", {31'd0, bus.ld_ready}, 32'd0);
        chk("rst.we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst.cnt", {23'd0, bus.ld_count}, 32'd0);
        chk("rst.addr", {24'd0, bus.mem_addr}, 32'd0);

        // Load three words; the last one lands in the cycle ld_req falls.
        bus.ld_req = 1;
        tick();
        chk("ld.ready", {31'd0, bus.ld_ready}, 32'd1);
        bus.ld_valid = 1; bus.ld_addr = 8'd0; bus.ld_data = 16'hA001;
        tick();
        bus.ld_addr = 8'd1; bus.ld_data = 16'hA002;
        tick();
        bus.ld_addr = 8'd2; bus.ld_data = 16'hA003; bus.ld_req = 0;
        tick();
        bus.ld_valid = 0;
        chk("ld.cnt", {23'd0, bus.ld_count}, 32'd3);
        chk("ld.exit", {31'd0, bus.ld_ready}, 32'd0);
        chk("ld.mem2", {16'd0, rd(8'd2)}, 32'h0000A003);

        // Run: bubble after start, then back-to-back fetches.
        bus.start = 1;
        tick();
        bus.start = 0;
        chk("run.first", {31'd0, bus.if_valid}, 32'd0);
        tick(); chk_out("run0", 16'h0000, 16'hA001);
        tick(); chk_out("run1", 16'h0001, 16'hA002);

        bus.if_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_out("stall", 16'h0001, 16'hA002);
        end
        bus.if_ready = 1;
        tick(); chk_out("unstall", 16'h0002, 16'hA003);
        tick(); chk_out("run3", 16'h0003, 16'h1003);

        bus.br_valid = 1; bus.br_target = 16'h0080;
        tick();
        bus.br_valid = 0;
        chk("br.bubble", {31'd0, bus.if_valid}, 32'd0);
        tick(); chk_out("br.tgt", 16'h0080, 16'h5555);
        tick(); chk_out("br.next", 16'h0081, 16'h1081);

        bus.if_ready = 0;
        tick(); chk_out("brst.hold", 16'h0081, 16'h1081);
        bus.br_valid = 1; bus.br_target = 16'h0080;
        tick();
        bus.br_valid = 0; bus.if_ready = 1;
        chk("brst.bubble", {31'd0, bus.if_valid}, 32'd0);
        tick(); chk_out("brst.tgt", 16'h0080, 16'h5555);

        bus.br_valid = 1; bus.br_target = 16'h00FF;
        tick();
        bus.br_valid = 0;
        tick(); chk_out("wrap.ff", 16'h00FF, 16'h10FF);
        chk("wrap.addr", {24'd0, bus.mem_addr}, 32'd0);
        tick(); chk_out("wrap.100", 16'h0100, 16'hA001);
        bus.br_valid = 1; bus.br_target = 16'hFFFF;
        tick();
        bus.br_valid = 0;
        tick(); chk_out("wrap.ffff", 16'hFFFF, 16'h10FF);
        tick(); chk_out("wrap.0", 16'h0000, 16'hA001);

        bus.br_valid = 1; bus.br_target = 16'h0005;
        tick();
        bus.br_valid = 0;
        tick(); chk_out("pre.halt", 16'h0005, 16'h1005);
        bus.halt_req = 1;
        tick();
        bus.halt_req = 0;
        chk("halt.h", {31'd0, bus.halted}, 32'd1);
        chk("halt.v", {31'd0, bus.if_valid}, 32'd0);
        tick();
        chk("halt.hold", {31'd0, bus.halted}, 32'd1);
        bus.start = 1;
        tick();
        bus.start = 0;
        chk("resume.h", {31'd0, bus.halted}, 32'd0);
        tick(); chk_out("resume", 16'h0006, 16'h1006);

        // Halt with a simultaneous redirect keeps the redirect target.
        bus.halt_req = 1; bus.br_valid = 1; bus.br_target = 16'h0020;
        tick();
        bus.halt_req = 0; bus.br_valid = 0;
        chk("halt2.h", {31'd0, bus.halted}, 32'd1);

        // Reload from HALT, overfilling to hit count saturation.
        bus.ld_req = 1;
        tick();
        chk("reld.cnt0", {23'd0, bus.ld_count}, 32'd0);
        chk("reld.h", {31'd0, bus.halted}, 32'd0);
        bus.ld_valid = 1;
        for (int i = 0; i <= 256; i++) begin
            bus.ld_addr = i[7:0];
            bus.ld_data = 16'hC000 + 16'(i);
            if (i == 256) bus.ld_req = 0;
            tick();
        end
        bus.ld_valid = 0;
        chk("reld.sat", {23'd0, bus.ld_count}, 32'd256);
        chk("reld.mem0", {16'd0, rd(8'd0)}, 32'h0000C100);
        bus.start = 1;
        tick();
        bus.start = 0;
        tick(); chk_out("reld.pc", 16'h0000, 16'hC100);

        bus.halt_req = 1;
        tick();
        bus.halt_req = 0;

        // Asynchronous reset in the middle of a LOAD write.
        bus.ld_req = 1;
        tick();
        bus.ld_valid = 1; bus.ld_addr = 8'd9; bus.ld_data = 16'h1234;
        tick();
        chk("rl.cnt1", {23'd0, bus.ld_count}, 32'd1);
        chk("rl.we", {31'd0, bus.mem_we}, 32'd1);
        #2;
        rst_n = 0;
        #1;
        chk("rl.we0", {31'd0, bus.mem_we}, 32'd0);
        chk("rl.rdy0", {31'd0, bus.ld_ready}, 32'd0);
        chk("rl.cnt0", {23'd0, bus.ld_count}, 32'd0);
        chk("rl.halted", {31'd0, bus.halted}, 32'd0);
        bus.ld_valid = 0; bus.ld_req = 0;
        tick();
        rst_n = 1;
        bus.start = 1;
        tick();
        bus.start = 0;
        tick(); chk_out("rl.run", 16'h0000, 16'hC100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
